// File: rtl/vga_timing_monitor.sv
// ---------------------------------------------------------------------------
// vga_timing_monitor
//
// Receive-side VGA timing monitor. Samples hsync/vsync/rgb from pads,
// measures line and frame timing, checks line-length stability, counts
// active pixel clocks and publishes one result set per frame over a
// valid/ack handshake.
//
// Optional feature: define VGA_MON_CRC_EN to add pix_crc, a CRC-16-CCITT
// (poly 0x1021, init 0xFFFF) over the 3 rgb bits (rgb[2] first) of every
// clock with both syncs inactive.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   hsync/vsync  asynchronous sync inputs from pads
//   rgb[2:0]     asynchronous colour bits from pads
//   frame_ack    single-cycle pulse consuming the current result set
//   frame_valid  result set available
//   overrun      sticky: result set overwritten before ack
//   locked       at least one complete frame measured since SEARCH
//   lost         sticky: hsync timeout occurred
//   h_total      clocks per line (last line of frame)
//   h_pulse      clocks hsync held asserted
//   v_total      lines per frame
//   v_pulse      lines with vsync asserted
//   h_stable     every line of the frame had the same length
//   pix_count    clocks with rgb != 0 while both syncs inactive
//   frame_cnt    completed-frame counter (wraps)
//   pix_crc      CRC of rgb stream (VGA_MON_CRC_EN only)
// ---------------------------------------------------------------------------
module vga_timing_monitor #(
    parameter int CW          = 16,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int LOST_CYCLES = 65535
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          hsync,
    input  logic          vsync,
    input  logic [2:0]    rgb,
    input  logic          frame_ack,
    output logic          frame_valid,
    output logic          overrun,
    output logic          locked,
    output logic          lost,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] h_pulse,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] v_pulse,
    output logic          h_stable,
    output logic [23:0]   pix_count,
    output logic [7:0]    frame_cnt
`ifdef VGA_MON_CRC_EN
    ,
    output logic [15:0]   pix_crc
`endif
);

    typedef enum logic {ST_SEARCH, ST_MEASURE} state_t;

    localparam logic          HS_LVL    = (HS_POL != 0);
    localparam logic          VS_LVL    = (VS_POL != 0);
    localparam logic [CW-1:0] LOST_LAST = CW'(LOST_CYCLES - 1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [2:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 2; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    // Synchronisers: stages 1-2 resynchronise, stage 3 (syncs only) for edges.
    logic [2:0] hs_sync_q, vs_sync_q;
    logic [2:0] rgb_s1_q, rgb_s2_q;

    state_t        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [CW-1:0] hp_cnt_q, hp_cnt_d;
    logic [CW-1:0] htot_w_q, htot_w_d;
    logic [CW-1:0] hpul_w_q, hpul_w_d;
    logic [CW-1:0] line_w_q, line_w_d;
    logic [CW-1:0] vpul_w_q, vpul_w_d;
    logic [CW-1:0] first_len_q, first_len_d;
    logic          first_vld_q, first_vld_d;
    logic          stable_w_q, stable_w_d;
    logic [23:0]   pix_w_q, pix_w_d;

    logic          frame_valid_q, frame_valid_d;
    logic          overrun_q, overrun_d;
    logic          locked_q, locked_d;
    logic          lost_q, lost_d;
    logic [CW-1:0] h_total_q, h_total_d;
    logic [CW-1:0] h_pulse_q, h_pulse_d;
    logic [CW-1:0] v_total_q, v_total_d;
    logic [CW-1:0] v_pulse_q, v_pulse_d;
    logic          h_stable_q, h_stable_d;
    logic [23:0]   pix_count_q, pix_count_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
`ifdef VGA_MON_CRC_EN
    logic [15:0]   crc_w_q, crc_w_d;
    logic [15:0]   pix_crc_q, pix_crc_d;
`endif

    // Asserted-level views of synchronised syncs (stage 2 = now, stage 3 = previous).
    logic hs_act, hs_act_prev, vs_act, vs_act_prev;
    logic h_lead, h_trail, v_lead, blank_n, pix_qual;
    logic [CW-1:0] line_len;

    assign hs_act      = (hs_sync_q[1] == HS_LVL);
    assign hs_act_prev = (hs_sync_q[2] == HS_LVL);
    assign vs_act      = (vs_sync_q[1] == VS_LVL);
    assign vs_act_prev = (vs_sync_q[2] == VS_LVL);
    assign h_lead      = hs_act & ~hs_act_prev;
    assign h_trail     = ~hs_act & hs_act_prev;
    assign v_lead      = vs_act & ~vs_act_prev;
    assign blank_n     = ~hs_act & ~vs_act;
    assign pix_qual    = blank_n & (rgb_s2_q != 3'b000);
    assign line_len    = sat_inc(clk_cnt_q);

    always_comb begin
        state_d       = state_q;
        clk_cnt_d     = clk_cnt_q;
        hp_cnt_d      = hp_cnt_q;
        htot_w_d      = htot_w_q;
        hpul_w_d      = hpul_w_q;
        line_w_d      = line_w_q;
        vpul_w_d      = vpul_w_q;
        first_len_d   = first_len_q;
        first_vld_d   = first_vld_q;
        stable_w_d    = stable_w_q;
        pix_w_d       = pix_w_q;
        frame_valid_d = frame_valid_q;
        overrun_d     = overrun_q;
        locked_d      = locked_q;
        lost_d        = lost_q;
        h_total_d     = h_total_q;
        h_pulse_d     = h_pulse_q;
        v_total_d     = v_total_q;
        v_pulse_d     = v_pulse_q;
        h_stable_d    = h_stable_q;
        pix_count_d   = pix_count_q;
        frame_cnt_d   = frame_cnt_q;
`ifdef VGA_MON_CRC_EN
        crc_w_d       = crc_w_q;
        pix_crc_d     = pix_crc_q;
`endif

        // Pulse-width counter runs in both states so a pulse straddling
        // the SEARCH->MEASURE transition is still measured correctly.
        if (h_lead) begin
            hp_cnt_d = CW'(1);
        end else if (hs_act) begin
            hp_cnt_d = sat_inc(hp_cnt_q);
        end

        if (frame_ack && frame_valid_q) begin
            frame_valid_d = 1'b0;
            overrun_d     = 1'b0;
        end
        if (frame_ack && lost_q) begin
            lost_d = 1'b0;
        end

        case (state_q)
            ST_SEARCH: begin
                locked_d = 1'b0;
                if (v_lead) begin
                    state_d     = ST_MEASURE;
                    clk_cnt_d   = '0;
                    htot_w_d    = '0;
                    hpul_w_d    = '0;
                    line_w_d    = '0;
                    vpul_w_d    = '0;
                    first_len_d = '0;
                    first_vld_d = 1'b0;
                    stable_w_d  = 1'b1;
                    pix_w_d     = '0;
`ifdef VGA_MON_CRC_EN
                    crc_w_d     = 16'hFFFF;
`endif
                end
            end

            default: begin
                clk_cnt_d = sat_inc(clk_cnt_q);
                if (pix_qual && (pix_w_q != 24'hFFFFFF)) begin
                    pix_w_d = pix_w_q + 24'd1;
                end
`ifdef VGA_MON_CRC_EN
                if (blank_n) begin
                    crc_w_d = crc_step(crc_w_q, rgb_s2_q);
                end
`endif
                if (h_lead) begin
                    clk_cnt_d = '0;
                    htot_w_d  = line_len;
                    line_w_d  = sat_inc(line_w_q);
                    if (vs_act) begin
                        vpul_w_d = sat_inc(vpul_w_q);
                    end
                    if (!first_vld_q) begin
                        first_len_d = line_len;
                        first_vld_d = 1'b1;
                    end else if (line_len != first_len_q) begin
                        stable_w_d = 1'b0;
                    end
                end
                if (h_trail) begin
                    hpul_w_d = hp_cnt_q;
                end

                // Publish uses the *_d working values so an hsync edge in
                // the same cycle is already folded into this frame.
                if (v_lead) begin
                    h_total_d   = htot_w_d;
                    h_pulse_d   = hpul_w_d;
                    v_total_d   = line_w_d;
                    v_pulse_d   = vpul_w_d;
                    h_stable_d  = stable_w_d;
                    pix_count_d = pix_w_d;
`ifdef VGA_MON_CRC_EN
                    pix_crc_d   = crc_w_d;
                    crc_w_d     = 16'hFFFF;
`endif
                    if (frame_valid_q && !frame_ack) begin
                        overrun_d = 1'b1;
                    end
                    frame_valid_d = 1'b1;
                    locked_d      = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 8'd1;
                    htot_w_d      = '0;
                    hpul_w_d      = '0;
                    line_w_d      = '0;
                    vpul_w_d      = '0;
                    first_vld_d   = 1'b0;
                    stable_w_d    = 1'b1;
                    pix_w_d       = '0;
                end else if (!h_lead && (clk_cnt_q == LOST_LAST)) begin
                    lost_d   = 1'b1;
                    locked_d = 1'b0;
                    state_d  = ST_SEARCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_sync_q     <= '0;
            vs_sync_q     <= '0;
            rgb_s1_q      <= '0;
            rgb_s2_q      <= '0;
            state_q       <= ST_SEARCH;
            clk_cnt_q     <= '0;
            hp_cnt_q      <= '0;
            htot_w_q      <= '0;
            hpul_w_q      <= '0;
            line_w_q      <= '0;
            vpul_w_q      <= '0;
            first_len_q   <= '0;
            first_vld_q   <= 1'b0;
            stable_w_q    <= 1'b0;
            pix_w_q       <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            locked_q      <= 1'b0;
            lost_q        <= 1'b0;
            h_total_q     <= '0;
            h_pulse_q     <= '0;
            v_total_q     <= '0;
            v_pulse_q     <= '0;
            h_stable_q    <= 1'b0;
            pix_count_q   <= '0;
            frame_cnt_q   <= '0;
`ifdef VGA_MON_CRC_EN
            crc_w_q       <= 16'hFFFF;
            pix_crc_q     <= '0;
`endif
        end else begin
            hs_sync_q     <= {hs_sync_q[1:0], hsync};
            vs_sync_q     <= {vs_sync_q[1:0], vsync};
            rgb_s1_q      <= rgb;
            rgb_s2_q      <= rgb_s1_q;
            state_q       <= state_d;
            clk_cnt_q     <= clk_cnt_d;
            hp_cnt_q      <= hp_cnt_d;
            htot_w_q      <= htot_w_d;
            hpul_w_q      <= hpul_w_d;
            line_w_q      <= line_w_d;
            vpul_w_q      <= vpul_w_d;
            first_len_q   <= first_len_d;
            first_vld_q   <= first_vld_d;
            stable_w_q    <= stable_w_d;
            pix_w_q       <= pix_w_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            locked_q      <= locked_d;
            lost_q        <= lost_d;
            h_total_q     <= h_total_d;
            h_pulse_q     <= h_pulse_d;
            v_total_q     <= v_total_d;
            v_pulse_q     <= v_pulse_d;
            h_stable_q    <= h_stable_d;
            pix_count_q   <= pix_count_d;
            frame_cnt_q   <= frame_cnt_d;
`ifdef VGA_MON_CRC_EN
            crc_w_q       <= crc_w_d;
            pix_crc_q     <= pix_crc_d;
`endif
        end
    end

    assign frame_valid = frame_valid_q;
    assign overrun     = overrun_q;
    assign locked      = locked_q;
    assign lost        = lost_q;
    assign h_total     = h_total_q;
    assign h_pulse     = h_pulse_q;
    assign v_total     = v_total_q;
    assign v_pulse     = v_pulse_q;
    assign h_stable    = h_stable_q;
    assign pix_count   = pix_count_q;
    assign frame_cnt   = frame_cnt_q;
`ifdef VGA_MON_CRC_EN
    assign pix_crc     = pix_crc_q;
`endif

endmodule
